// File: rtl/id_stage_fwd.sv
// MIPS decode stage: register file with write-through, operand forwarding, interlocks,
// branch/jump resolution and the D/E pipeline register. Optional macro: ID_DELAY_SLOT_EN.
module id_stage_fwd #(
  parameter int unsigned DW       = 32,
  parameter int unsigned NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr_D,
  input  logic [31:0]   pc_D,
  input  logic          valid_D,
  input  logic          hold_E,
  input  logic          e_we,
  input  logic          e_load,
  input  logic [AW-1:0] e_addr,
  input  logic          m_we,
  input  logic          m_load,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          stall_D,
  output logic          redirect,
  output logic [31:0]   redirect_pc,
  output logic          flush_F,
  output logic          valid_E,
  output logic [DW-1:0] rs_val_E,
  output logic [DW-1:0] rt_val_E,
  output logic [DW-1:0] imm_E,
  output logic [31:0]   pc_E,
  output logic [31:0]   instr_E,
  output logic [AW-1:0] dst_E,
  output logic          we_E
);

  logic [DW-1:0] r_rf [NREG];

  logic [5:0]    w_op, w_funct;
  logic [AW-1:0] w_rs, w_rt, w_rd;
  logic [15:0]   w_imm;
  logic w_rtype, w_jr, w_jalr, w_regimm, w_j, w_jal, w_beq, w_bne, w_blez, w_bgtz;
  logic w_alui, w_lui, w_logic_imm, w_load, w_store, w_branch;
  logic w_use_rs, w_use_rt, w_ctl_src;

  assign w_op    = instr_D[31:26];
  assign w_funct = instr_D[5:0];
  assign w_rs    = AW'(instr_D[25:21]);
  assign w_rt    = AW'(instr_D[20:16]);
  assign w_rd    = AW'(instr_D[15:11]);
  assign w_imm   = instr_D[15:0];

  assign w_rtype     = (w_op == 6'h00);
  assign w_jr        = w_rtype && (w_funct == 6'h08);
  assign w_jalr      = w_rtype && (w_funct == 6'h09);
  assign w_regimm    = (w_op == 6'h01);
  assign w_j         = (w_op == 6'h02);
  assign w_jal       = (w_op == 6'h03);
  assign w_beq       = (w_op == 6'h04);
  assign w_bne       = (w_op == 6'h05);
  assign w_blez      = (w_op == 6'h06);
  assign w_bgtz      = (w_op == 6'h07);
  assign w_alui      = (w_op[5:3] == 3'b001);
  assign w_lui       = (w_op == 6'h0F);
  assign w_logic_imm = (w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0E);
  assign w_load      = (w_op[5:3] == 3'b100);
  assign w_store     = (w_op[5:3] == 3'b101);
  assign w_branch    = w_regimm || w_beq || w_bne || w_blez || w_bgtz;

  assign w_use_rs  = w_rtype || (w_alui && !w_lui) || w_load || w_store || w_branch;
  assign w_use_rt  = w_rtype || w_beq || w_bne || w_store;
  assign w_ctl_src = w_branch || w_jr || w_jalr;

  // M forwarding excludes loads: their data is not ready until W.
  logic [DW-1:0] w_rs_val, w_rt_val;
  assign w_rs_val = (w_rs == '0) ? '0 :
                    (m_we && !m_load && (m_addr == w_rs)) ? m_data :
                    (wb_we && (wb_addr == w_rs)) ? wb_data : r_rf[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 :
                    (m_we && !m_load && (m_addr == w_rt)) ? m_data :
                    (wb_we && (wb_addr == w_rt)) ? wb_data : r_rf[w_rt];

  logic w_e_hit, w_m_hit, w_interlock, w_advance;
  assign w_e_hit = e_we && (e_addr != '0) &&
                   ((w_use_rs && (e_addr == w_rs)) || (w_use_rt && (e_addr == w_rt)));
  assign w_m_hit = m_load && (m_addr != '0) &&
                   ((w_use_rs && (m_addr == w_rs)) || (w_use_rt && (m_addr == w_rt)));
  assign w_interlock = valid_D && ((e_load && w_e_hit) || (w_ctl_src && (w_e_hit || w_m_hit)));
  assign w_advance   = valid_D && !w_interlock;

  logic w_eq, w_neg, w_zero, w_take, w_redirect;
  assign w_eq   = (w_rs_val == w_rt_val);
  assign w_neg  = w_rs_val[DW-1];
  assign w_zero = (w_rs_val == '0);
  assign w_take = (w_beq && w_eq) || (w_bne && !w_eq) ||
                  (w_blez && (w_neg || w_zero)) || (w_bgtz && !(w_neg || w_zero)) ||
                  (w_regimm && (instr_D[16] ? !w_neg : w_neg)) ||
                  w_j || w_jal || w_jr || w_jalr;
  assign w_redirect = w_advance && !hold_E && w_take;

  logic [31:0] w_target;
  always_comb begin
    w_target = pc_D + 32'd4 + {{14{w_imm[15]}}, w_imm, 2'b00};
    if (w_j || w_jal) begin
      w_target = {pc_D[31:28], instr_D[25:0], 2'b00};
    end else if (w_jr || w_jalr) begin
      w_target = 32'(w_rs_val);
    end
  end

  logic [DW-1:0] w_link;
`ifdef ID_DELAY_SLOT_EN
  assign w_link  = DW'(pc_D + 32'd8);
  assign flush_F = 1'b0;
`else
  assign w_link  = DW'(pc_D + 32'd4);
  assign flush_F = reset && w_redirect;
`endif

  assign stall_D     = reset && (hold_E || w_interlock);
  assign redirect    = reset && w_redirect;
  assign redirect_pc = reset ? w_target : 32'h0;

  logic [DW-1:0] w_imm_ext;
  logic [AW-1:0] w_dst;
  assign w_imm_ext = w_logic_imm ? DW'(w_imm) :
                     w_lui       ? DW'({w_imm, 16'h0000}) : {{(DW-16){w_imm[15]}}, w_imm};
  assign w_dst     = w_rtype ? w_rd : (w_jal ? AW'(31) : w_rt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (wb_we && (wb_addr != '0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  logic          r_valid_E, r_we_E;
  logic [DW-1:0] r_rs_val_E, r_rt_val_E, r_imm_E;
  logic [31:0]   r_pc_E, r_instr_E;
  logic [AW-1:0] r_dst_E;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid_E  <= 1'b0;
      r_we_E     <= 1'b0;
      r_rs_val_E <= '0;
      r_rt_val_E <= '0;
      r_imm_E    <= '0;
      r_pc_E     <= RESET_PC;
      r_instr_E  <= '0;
      r_dst_E    <= '0;
    end else if (!hold_E) begin
      if (w_advance) begin
        r_valid_E  <= 1'b1;
        r_we_E     <= !(w_store || w_branch || w_j || w_jr);
        r_rs_val_E <= (w_jal || w_jalr) ? w_link : w_rs_val;
        r_rt_val_E <= w_rt_val;
        r_imm_E    <= w_imm_ext;
        r_pc_E     <= pc_D;
        r_instr_E  <= instr_D;
        r_dst_E    <= w_dst;
      end else begin
        r_valid_E <= 1'b0;
        r_we_E    <= 1'b0;
      end
    end
  end

  assign valid_E  = r_valid_E;
  assign we_E     = r_we_E;
  assign rs_val_E = r_rs_val_E;
  assign rt_val_E = r_rt_val_E;
  assign imm_E    = r_imm_E;
  assign pc_E     = r_pc_E;
  assign instr_E  = r_instr_E;
  assign dst_E    = r_dst_E;

endmodule
